// File: rtl/counter.sv
// WIDTH-bit up/down counter with parallel load, hold and terminal-count flag.
// Priority on each rising clk edge: load > hold > count (up/down).
// Build option: define COUNTER_SAT_EN to saturate at the end points instead
// of wrapping modulo 2^WIDTH. The default build (macro undefined) wraps.
module counter #(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic [WIDTH-1:0] d,
  input  logic             up,
  input  logic             hold,
  output logic [WIDTH-1:0] q,
  output logic             tc
);

  localparam logic [WIDTH-1:0] MAX_VAL = {WIDTH{1'b1}};
  localparam logic [WIDTH-1:0] MIN_VAL = {WIDTH{1'b0}};
  localparam logic [WIDTH-1:0] ONE     = {{(WIDTH-1){1'b0}}, 1'b1};

  logic             at_max;
  logic             at_min;
  logic [WIDTH-1:0] q_inc;
  logic [WIDTH-1:0] q_dec;
  logic [WIDTH-1:0] next_q;

  assign at_max = (q == MAX_VAL);
  assign at_min = (q == MIN_VAL);

  // Step values in each direction; saturating build pins at the end points.
  always_comb begin
`ifdef COUNTER_SAT_EN
    q_inc = at_max ? MAX_VAL : q + ONE;
    q_dec = at_min ? MIN_VAL : q - ONE;
`else
    q_inc = q + ONE;
    q_dec = q - ONE;
`endif
  end

  // Next count in priority order: load, then hold, then direction.
  always_comb begin
    next_q = q;
    if (load) begin
      next_q = d;
    end else if (hold) begin
      next_q = q;
    end else if (up) begin
      next_q = q_inc;
    end else begin
      next_q = q_dec;
    end
  end

  // Count register; reset clears it without waiting for a clock edge.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      q <= MIN_VAL;
    end else begin
      q <= next_q;
    end
  end

  // The next edge would wrap (or saturate) only when actually counting.
  assign tc = ~load & ~hold & (up ? at_max : at_min);

endmodule

// File: tb/tb_counter.sv
// Scoreboard bench for counter (WIDTH=4). The driver pushes, per clock, the
// hand-computed tc before the edge and q after it; the monitor pops and checks.
module tb_counter;

`ifdef COUNTER_SAT_EN
  localparam bit SAT = 1'b1;
`else
  localparam bit SAT = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       load = 1'b0;
  logic [3:0] d = 4'd5;
  logic       up = 1'b1;
  logic       hold = 1'b0;
  logic [3:0] q;
  logic       tc;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [3:0] q_exp;
    logic       tc_exp;
    string      name;
  } exp_t;

  exp_t sb[$];

  counter #(.WIDTH(4)) dut (
    .clk  (clk),
    .rst  (rst),
    .load (load),
    .d    (d),
    .up   (up),
    .hold (hold),
    .q    (q),
    .tc   (tc)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0d required=%0d", name, act, exp);
    end
  endtask

  // Drive one vector at the falling edge and queue its expected response.
  task automatic step(input logic ld, input logic [3:0] dv, input logic u, input logic h,
                      input logic tc_pre, input logic [3:0] q_post, input string name);
    exp_t e;
    @(negedge clk);
    rst  = 1'b0;
    load = ld;
    d    = dv;
    up   = u;
    hold = h;
    e.q_exp  = q_post;
    e.tc_exp = tc_pre;
    e.name   = name;
    sb.push_back(e);
  endtask

  task automatic drain();
    int n;
    n = 0;
    while (sb.size() != 0 && n < 20) begin
      @(posedge clk);
      n++;
    end
    #2;
    if (sb.size() != 0) begin
      chk("scoreboard_drain_timeout", sb.size(), 0);
      sb.delete();
    end
  endtask

  // Monitor: tc is checked mid low phase, q just after the following edge.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      #2;
      if (sb.size() != 0) begin
        e = sb[0];
        chk({e.name, "_tc"}, tc, e.tc_exp);
        @(posedge clk);
        #1;
        e = sb.pop_front();
        chk({e.name, "_q"}, q, e.q_exp);
      end
    end
  end

  initial begin
    // Reset held through the first edge with load off and up set.
    #7;
    chk("reset_q", q, 0);
    chk("reset_tc", tc, 0);

    step(1, 4'd5, 1, 0, 0, 4'd5, "load5");
    for (int i = 0; i < 6; i++) step(0, 4'd0, 1, 0, 0, 4'(6 + i), "count_up");
    for (int i = 0; i < 3; i++) step(0, 4'd0, 1, 1, 0, 4'd11, "hold");
    for (int i = 0; i < 4; i++) step(0, 4'd0, 0, 0, 0, 4'(10 - i), "count_down");

    step(1, 4'd15, 1, 0, 0, 4'd15, "load15");
    step(0, 4'd0, 1, 0, 1, SAT ? 4'd15 : 4'd0, "wrap_up");
    step(0, 4'd0, 1, 0, SAT ? 1'b1 : 1'b0, SAT ? 4'd15 : 4'd1, "after_wrap_up");

    step(1, 4'd0, 0, 0, 0, 4'd0, "load0");
    step(0, 4'd0, 0, 0, 1, SAT ? 4'd0 : 4'd15, "wrap_down");
    step(0, 4'd0, 0, 0, SAT ? 1'b1 : 1'b0, SAT ? 4'd0 : 4'd14, "after_wrap_down");

    step(1, 4'd3, 1, 0, 0, 4'd3, "load3");
    step(1, 4'd9, 1, 1, 0, 4'd9, "load_over_hold");
    step(0, 4'd0, 1, 1, 0, 4'd9, "hold_after_load");
    step(1, 4'd15, 1, 0, 0, 4'd15, "load15b");
    step(0, 4'd0, 1, 1, 0, 4'd15, "hold_masks_tc");

    step(1, 4'd7, 1, 0, 0, 4'd7, "load7");
    drain();

    // Asynchronous reset in the middle of the low phase while counting.
    @(negedge clk);
    load = 1'b0;
    up   = 1'b1;
    hold = 1'b0;
    #2;
    chk("pre_async_q", q, 7);
    rst = 1'b1;
    #1;
    chk("async_reset_q", q, 0);
    chk("async_reset_tc", tc, 0);
    load = 1'b1;
    d    = 4'd9;
    @(posedge clk);
    #1;
    chk("reset_beats_load_q", q, 0);

    step(0, 4'd0, 1, 0, 0, 4'd1, "first_after_release");
    step(0, 4'd0, 0, 0, 0, 4'd0, "down_to_zero");
    step(0, 4'd0, 0, 0, 1, SAT ? 4'd0 : 4'd15, "tc_down_at_zero");
    drain();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
